// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - ST_IDLE / ST_SHIFT / ST_DONE : 2-bit state encodings
//   - state_e                      : FSM state type built on those encodings
//   - ADD3_THRESH                  : nibble value at which the +3 adjust fires
//   - bcd_width(w)                 : BCD field width needed for a w-bit input
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

  localparam logic [3:0] ADD3_THRESH = 4'd5;

  // Enough BCD bits to hold the largest w-bit value: w+(w-4)/3+1.
  function automatic int bcd_width(input int w);
    return w + (w - 4) / 3 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq_if
// Start/Done handshake bundle between a requester and bin2bcd_seq.
//   Start : conversion request (requester -> converter)
//   Bin   : W-bit binary value (requester -> converter)
//   Busy  : conversion iterating (converter -> requester)
//   Done  : one-cycle pulse when Bcd is updated (converter -> requester)
//   Bcd   : packed BCD result, digit i at [4i+3:4i] (converter -> requester)
//   Neg   : sign of the last result, only with BIN2BCD_SIGNED_EN defined
// Modports: master (requester side), slave (converter side).
// ---------------------------------------------------------------------------
interface bin2bcd_seq_if #(
  parameter int W = 32
);
  import bin2bcd_pkg::*;

  localparam int BW = bcd_width(W);

  logic          Start;
  logic [W-1:0]  Bin;
  logic          Busy;
  logic          Done;
  logic [BW-1:0] Bcd;
`ifdef BIN2BCD_SIGNED_EN
  logic          Neg;

  modport master (output Start, Bin, input Busy, Done, Bcd, Neg);
  modport slave  (input Start, Bin, output Busy, Done, Bcd, Neg);
`else
  modport master (output Start, Bin, input Busy, Done, Bcd);
  modport slave  (input Start, Bin, output Busy, Done, Bcd);
`endif

endinterface

// File: rtl/bcd_add3_adj.sv
// ---------------------------------------------------------------------------
// bcd_add3_adj
// Combinational double-dabble correction: every nibble whose value is 5 or
// more gets +3 (4-bit wrap, no carry into the next nibble), so that the
// following left shift carries correctly into the next decimal digit.
//   bcd_i : ND packed BCD nibbles before correction
//   bcd_o : ND packed BCD nibbles after correction
// ---------------------------------------------------------------------------
module bcd_add3_adj
  import bin2bcd_pkg::*;
#(
  parameter int ND = 11
) (
  input  logic [4*ND-1:0] bcd_i,
  output logic [4*ND-1:0] bcd_o
);

  for (genvar g = 0; g < ND; g++) begin : gen_nib
    assign bcd_o[4*g +: 4] = (bcd_i[4*g +: 4] >= ADD3_THRESH) ?
                             bcd_i[4*g +: 4] + 4'd3 : bcd_i[4*g +: 4];
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// A request accepted in cycle 0 keeps Busy high in cycles 1..W and pulses
// Done with the new Bcd in cycle W+1. Bcd holds the previous result while a
// new conversion runs. Start is accepted in IDLE and DONE only.
//   Clk   : system clock
//   Rst_n : synchronous active-low reset
//   bus   : bin2bcd_seq_if slave (Start, Bin, Busy, Done, Bcd[, Neg])
// Optional build macro BIN2BCD_SIGNED_EN: Bin is two's complement, the
// magnitude is converted and the registered sign comes out on Neg.
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W = 32
) (
  input  logic          Clk,
  input  logic          Rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int BW = bcd_width(W);
  localparam int CW = $clog2(W + 1);
  localparam int ND = (BW + 3) / 4;
  localparam int PW = 4 * ND;
  localparam int SW = BW + W;

  state_e         state_q, state_d;
  logic [SW-1:0]  sreg_q, sreg_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bcd_q, bcd_d;
  logic           neg_q, neg_d;
  logic           negPend_q, negPend_d;

  logic [PW-1:0]  fieldPad;
  logic [PW-1:0]  fieldAdj;
  logic [SW-1:0]  adjusted;
  logic [W-1:0]   loadVal;

`ifdef BIN2BCD_SIGNED_EN
  // Negating in W bits and reading the result as unsigned gives the exact
  // magnitude, including 2^(W-1) for the most negative input.
  assign loadVal = bus.Bin[W-1] ? (~bus.Bin + 1'b1) : bus.Bin;
`else
  assign loadVal = bus.Bin;
`endif

  // The BCD field is padded up to whole nibbles; the pad always stays zero.
  assign fieldPad = PW'(sreg_q[SW-1:W]);

  bcd_add3_adj #(.ND(ND)) u_adj (
    .bcd_i (fieldPad),
    .bcd_o (fieldAdj)
  );

  assign adjusted = {fieldAdj[BW-1:0], sreg_q[W-1:0]};

  if (PW > BW) begin : gen_pad
    logic unusedPad;
    assign unusedPad = &{1'b0, fieldAdj[PW-1:BW]};
  end

  // State and datapath registers; reset also discards any partial result.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      negPend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      negPend_q <= negPend_d;
    end
  end

  // Next-state logic. SHIFT runs W times; on the last one the post-shift
  // BCD field is copied into the output register so Done and Bcd align.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    negPend_d = negPend_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.Start) begin
          sreg_d    = {{BW{1'b0}}, loadVal};
          cnt_d     = '0;
          negPend_d = bus.Bin[W-1];
          state_d   = SHIFT;
        end else begin
          state_d   = IDLE;
        end
      end
      SHIFT: begin
        sreg_d = {adjusted[SW-2:0], 1'b0};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          bcd_d   = adjusted[SW-2:W-1];
          neg_d   = negPend_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Busy = (state_q == SHIFT);
  assign bus.Done = (state_q == DONE);
  assign bus.Bcd  = bcd_q;
`ifdef BIN2BCD_SIGNED_EN
  assign bus.Neg  = neg_q;
`else
  logic unusedNeg;
  assign unusedNeg = &{1'b0, neg_q};
`endif

endmodule
